kahan_stream_accum: RTL and testbench
=====================================

// Module: kahan_stream_accum
// PURPOSE
//   Streaming, frame-based, compensated reduction of LANES signed integers per beat.
//   Each accepted beat passes through a registered lane-reduction tree, then a running
//   accumulator. The accumulator keeps a coarse sum plus a FRAC_DROP-bit compensation
//   residual, so floor(total/2^FRAC_DROP) is exact over arbitrarily long frames.
//   It replaces single-shot adder trees where vectors arrive over many cycles.
// PARAMETERS
//   DATA_WIDTH  8   width of each signed input element
//   LANES       8   elements per beat; power of two, >=2
//   MAX_BEATS   256 maximum beats per frame
//   FRAC_DROP   4   LSBs of each beat sum routed to compensation (>=1, <DATA_WIDTH)
//   SUM_WIDTH_O 24  width of signed coarse output sum
//   BW          derived: $clog2(MAX_BEATS+1)
// PORTS
//   clk_i        in   1                    clock, rising edge
//   rst_i        in   1                    synchronous, active-high reset
//   cfg_beats_i  in   BW                   beats in next frame; sampled on the frame's first accepted beat
//   cfg_sat_i    in   1                    1=saturate on overflow, 0=wrap; sampled with cfg_beats_i
//   in_valid_i   in   1                    input beat valid
//   in_ready_o   out  1                    block can accept a beat
//   in_vec_i     in   LANES*DATA_WIDTH     packed signed elements; lane k = bits [k*DW +: DW]
//   out_valid_o  out  1                    frame result valid
//   out_ready_i  in   1                    consumer accepts result
//   out_sum_o    out  SUM_WIDTH_O          signed floor(frame total / 2^FRAC_DROP)
//   out_comp_o   out  FRAC_DROP            unsigned residual: frame total mod 2^FRAC_DROP
//   out_ovf_o    out  1                    sticky: coarse sum overflowed during the frame
// BEHAVIOUR
//   Reset (rst_i=1 at clk edge)
//     - state=IDLE; in_ready_o=1; out_valid_o=0; out_sum_o=0; out_comp_o=0; out_ovf_o=0.
//     - Pipeline, beat counter and accumulators are cleared.
//     - Reset mid-frame discards the partial frame; no result is emitted.
//   Handshakes
//     - Input beat accepted when in_valid_i & in_ready_o.
//     - Result consumed when out_valid_o & out_ready_i.
//     - out_* are held stable while out_valid_o=1 and out_ready_i=0.
//   FSM
//     - IDLE: in_ready_o=1. On the first accepted beat, latch cfg; effective beats N =
//       (cfg_beats_i==0 ? 1 : min(cfg_beats_i, MAX_BEATS)); clear accumulators; remaining=N-1.
//       If N==1 go to DRAIN, else go to ACCUM.
//     - ACCUM: in_ready_o=1. Each accepted beat decrements remaining. The beat that makes
//       remaining 0 is the last; go to DRAIN.
//     - DRAIN: in_ready_o=0. Wait for the last beat to pass stage 2, then set
//       out_valid_o=1 and go to HOLD.
//     - HOLD: in_ready_o=0. On result consumed: out_valid_o=0, go to IDLE. A new frame
//       can be accepted the following cycle.
//   Datapath
//     - Stage 1 (register): beat sum s = signed sum of all lanes, width DATA_WIDTH+$clog2(LANES).
//     - Stage 2 (register), per valid s:
//       - t = comp + s[FRAC_DROP-1:0] (unsigned, FRAC_DROP+1 bits).
//       - comp <= t[FRAC_DROP-1:0].
//       - sum <= sum + (s >>> FRAC_DROP) + t[FRAC_DROP], sign-extended to SUM_WIDTH_O.
//     - Overflow: true signed result outside the SUM_WIDTH_O range sets ovf (sticky per frame).
//       - cfg_sat=1: clamp sum to max/min.
//       - cfg_sat=0: wrap modulo 2^SUM_WIDTH_O.
//     - Latency: last beat accepted at edge t -> out_valid_o=1 after edge t+3 (s at t+1,
//       accumulate at t+2, publish at t+3).
//     - Throughput: 1 beat/cycle within a frame.
// TESTING
//   1. LANES=8, one frame N=1, all lanes=+3 -> total 24: out_sum=1, out_comp=8, ovf=0,
//      valid 3 cycles after accept.
//   2. N=4, every lane=+1 (s=8 per beat) -> total 32: out_sum=2, comp=0; input bubbles
//      between beats give the same result.
//   3. Residual carry: N=16 beats, s=1 each (lane0=1, others 0) -> out_sum=1, comp=0;
//      must match a 16-bit reference floor.
//   4. Signed: N=2, all lanes=-1 (s=-8) -> total -16: out_sum=-1, comp=0; lane0=-1 only
//      -> total -2: out_sum=-1, comp=14.
//   5. Overflow (SUM_WIDTH_O=8): N=64, all lanes=+127:
//      - sat=1 -> out_sum=127, ovf=1;
//      - sat=0 -> wrapped value matching the model, ovf=1.
//   6. Backpressure and reset:
//      - hold out_ready_i=0 for 10 cycles -> out_* stable, in_ready_o=0;
//      - assert rst_i mid-ACCUM -> all outputs 0, next frame result unaffected.

Source files
------------

// File: rtl/kahan_stream_accum.sv
// Frame-based streaming reduction of LANES signed elements per beat, with a
// compensated accumulator so floor(total/2^FRAC_DROP) stays exact over long frames.
module kahan_stream_accum #(
  parameter int DATA_WIDTH  = 8,
  parameter int LANES       = 8,
  parameter int MAX_BEATS   = 256,
  parameter int FRAC_DROP   = 4,
  parameter int SUM_WIDTH_O = 24,
  parameter int BW          = $clog2(MAX_BEATS + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [BW-1:0]                 cfg_beats_i,
  input  logic                          cfg_sat_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0]   in_vec_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic signed [SUM_WIDTH_O-1:0] out_sum_o,
  output logic [FRAC_DROP-1:0]          out_comp_o,
  output logic                          out_ovf_o
);
  localparam int SW = DATA_WIDTH + $clog2(LANES);
  localparam int XW = ((SUM_WIDTH_O > SW) ? SUM_WIDTH_O : SW) + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       remaining_q, remaining_d;
  logic                sat_q, sat_d;
  logic                accept, first_beat, last_beat;
  logic [BW-1:0]       n_eff;

  logic [LANES*DATA_WIDTH-1:0] vec_p0_q;
  logic                        vld_p0_q, last_p0_q;
  logic signed [SW-1:0]        lane_sum;
  logic signed [SW-1:0]        s_p1_q;
  logic                        vld_p1_q, last_p1_q;
  logic [FRAC_DROP:0]          t_p2;
  logic signed [XW-1:0]        wide_p2;
  logic signed [SUM_WIDTH_O-1:0] sum_p2_q;
  logic [FRAC_DROP-1:0]        comp_p2_q;
  logic                        ovf_p2_q, last_p2_q;

  function automatic logic [BW-1:0] eff_beats(input logic [BW-1:0] cfg);
    if (cfg == '0)                  return BW'(1);
    else if (cfg > BW'(MAX_BEATS))  return BW'(MAX_BEATS);
    else                            return cfg;
  endfunction

  function automatic logic fits(input logic signed [XW-1:0] v);
    logic [XW-SUM_WIDTH_O:0] hi;
    hi = v[XW-1:SUM_WIDTH_O-1];
    return (&hi) | (~|hi);
  endfunction

  function automatic logic signed [SUM_WIDTH_O-1:0] sat_wrap(input logic signed [XW-1:0] v,
                                                             input logic sat);
    if (fits(v) || !sat) return v[SUM_WIDTH_O-1:0];
    return v[XW-1] ? {1'b1, {(SUM_WIDTH_O-1){1'b0}}} : {1'b0, {(SUM_WIDTH_O-1){1'b1}}};
  endfunction

  assign accept      = in_valid_i & in_ready_o;
  assign n_eff       = eff_beats(cfg_beats_i);
  assign out_valid_o = (state_q == HOLD);
  assign out_sum_o   = sum_p2_q;
  assign out_comp_o  = comp_p2_q;
  assign out_ovf_o   = ovf_p2_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sat_d       = sat_q;
    in_ready_o  = 1'b0;
    first_beat  = 1'b0;
    last_beat   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          first_beat  = 1'b1;
          sat_d       = cfg_sat_i;
          remaining_d = n_eff - BW'(1);
          if (n_eff == BW'(1)) begin
            last_beat = 1'b1;
            state_d   = DRAIN;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          remaining_d = remaining_q - BW'(1);
          if (remaining_q == BW'(1)) begin
            last_beat = 1'b1;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: if (last_p2_q) state_d = HOLD;
      HOLD:  if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: lane reduction of the captured beat
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++)
      lane_sum += SW'($signed(vec_p0_q[k*DATA_WIDTH +: DATA_WIDTH]));
  end

  // Stage 2: low bits go to the residual, its carry-out feeds the coarse sum
  always_comb begin
    t_p2    = {1'b0, comp_p2_q} + {1'b0, s_p1_q[FRAC_DROP-1:0]};
    wide_p2 = XW'(sum_p2_q) + XW'(s_p1_q >>> FRAC_DROP) + XW'($signed({1'b0, t_p2[FRAC_DROP]}));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      sat_q       <= 1'b0;
      vld_p0_q    <= 1'b0;
      last_p0_q   <= 1'b0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      last_p2_q   <= 1'b0;
      sum_p2_q    <= '0;
      comp_p2_q   <= '0;
      ovf_p2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sat_q       <= sat_d;
      vld_p0_q    <= accept;
      last_p0_q   <= accept & last_beat;
      vld_p1_q    <= vld_p0_q;
      last_p1_q   <= last_p0_q;
      last_p2_q   <= last_p1_q;
      if (accept && first_beat) begin
        sum_p2_q  <= '0;
        comp_p2_q <= '0;
        ovf_p2_q  <= 1'b0;
      end else if (vld_p1_q) begin
        sum_p2_q  <= sat_wrap(wide_p2, sat_q);
        comp_p2_q <= t_p2[FRAC_DROP-1:0];
        ovf_p2_q  <= ovf_p2_q | ~fits(wide_p2);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept)   vec_p0_q <= in_vec_i;
    if (vld_p0_q) s_p1_q   <= lane_sum;
  end

endmodule

// File: tb/tb_kahan_stream_accum.sv
// Bench for kahan_stream_accum: directed and random frames against a
// running-total floor/mod reference model.
module tb_kahan_stream_accum;
  localparam int DW = 8, LN = 8, MB = 256, FD = 4, SWO = 8, BW = 9;
  localparam longint SMAX  = 127;
  localparam longint SMIN  = -128;
  localparam longint RANGE = 256;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [BW-1:0]         cfg_beats;
  logic                  cfg_sat;
  logic                  in_valid;
  logic                  in_ready;
  logic [LN*DW-1:0]      in_vec;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [SWO-1:0] out_sum;
  logic [FD-1:0]         out_comp;
  logic                  out_ovf;

  int checks = 0;
  int errors = 0;
  longint beat_tot[$];

  kahan_stream_accum #(
    .DATA_WIDTH(DW), .LANES(LN), .MAX_BEATS(MB), .FRAC_DROP(FD), .SUM_WIDTH_O(SWO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cfg_beats_i(cfg_beats), .cfg_sat_i(cfg_sat),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_vec_i(in_vec),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_sum_o(out_sum),
    .out_comp_o(out_comp), .out_ovf_o(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: the coarse output tracks floor(running_total / 2^FD); each beat moves
  // it by the change in that floor, then overflow handling applies to the new value.
  function automatic void model(input bit sat, output longint esum, output longint ecomp,
                                output longint eovf);
    longint tot, fl, prev, acc, v;
    tot = 0; prev = 0; acc = 0; eovf = 0;
    foreach (beat_tot[k]) begin
      tot += beat_tot[k];
      fl = tot >>> FD;
      v = acc + fl - prev;
      prev = fl;
      if (v > SMAX || v < SMIN) begin
        eovf = 1;
        if (sat) acc = (v > SMAX) ? SMAX : SMIN;
        else     acc = ((v - SMIN) % RANGE + RANGE) % RANGE + SMIN;
      end else begin
        acc = v;
      end
    end
    esum  = acc;
    ecomp = tot - ((tot >>> FD) <<< FD);
  endfunction

  task automatic make_beat(input int mode, input int val, output logic [LN*DW-1:0] v,
                           output longint tot);
    int e;
    v = '0; tot = 0;
    for (int k = 0; k < LN; k++) begin
      if (mode == 0)      e = val;
      else if (mode == 1) e = (k == 0) ? val : 0;
      else                e = int'($urandom_range(0, 2 * val)) - val;
      v[k*DW +: DW] = e[DW-1:0];
      tot += longint'(e);
    end
  endtask

  // Call at a negedge; returns at a negedge with the result consumed.
  task automatic run_frame(input string tag, input int cfg, input bit sat, input int mode,
                           input int val, input int max_bubble, input int hold);
    int n, b;
    longint esum, ecomp, eovf, tot;
    logic [LN*DW-1:0] v;
    n = (cfg == 0) ? 1 : ((cfg > MB) ? MB : cfg);
    out_ready = 1'b0;
    beat_tot.delete();
    for (int i = 0; i < n; i++) begin
      b = (max_bubble > 0) ? int'($urandom_range(0, max_bubble)) : 0;
      repeat (b) @(negedge clk);
      make_beat(mode, val, v, tot);
      beat_tot.push_back(tot);
      in_vec   = v;
      in_valid = 1'b1;
      if (i == 0) begin
        cfg_beats = BW'(cfg);
        cfg_sat   = sat;
      end else begin
        cfg_beats = BW'($urandom);
        cfg_sat   = 1'($urandom);
      end
      if (i == 0 || i == n - 1 || b > 0) chk({tag, ".in_ready"}, longint'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk({tag, ".drain_ready"}, longint'(in_ready), 0);
    for (int c = 0; c < 3; c++) begin
      chk({tag, ".early_valid"}, longint'(out_valid), 0);
      @(negedge clk);
    end
    chk({tag, ".valid"}, longint'(out_valid), 1);
    model(sat, esum, ecomp, eovf);
    chk({tag, ".sum"},  longint'(out_sum), esum);
    chk({tag, ".comp"}, longint'(out_comp), ecomp);
    chk({tag, ".ovf"},  longint'(out_ovf), eovf);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, ".hold_valid"}, longint'(out_valid), 1);
      chk({tag, ".hold_ready"}, longint'(in_ready), 0);
      chk({tag, ".hold_sum"},   longint'(out_sum), esum);
      chk({tag, ".hold_comp"},  longint'(out_comp), ecomp);
      chk({tag, ".hold_ovf"},   longint'(out_ovf), eovf);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".consumed"}, longint'(out_valid), 0);
    chk({tag, ".idle_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1; cfg_beats = '0; cfg_sat = 1'b0; in_valid = 1'b0;
    in_vec = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset.in_ready", longint'(in_ready), 1);
    chk("reset.out_valid", longint'(out_valid), 0);
    chk("reset.sum", longint'(out_sum), 0);
    chk("reset.comp", longint'(out_comp), 0);
    chk("reset.ovf", longint'(out_ovf), 0);

    run_frame("t1_single", 1, 1'b1, 0, 3, 0, 0);
    run_frame("t2_ones", 4, 1'b1, 0, 1, 0, 0);
    run_frame("t2_bubbles", 4, 1'b1, 0, 1, 3, 0);
    run_frame("t3_carry", 16, 1'b1, 1, 1, 0, 0);
    run_frame("t4_neg_all", 2, 1'b1, 0, -1, 0, 0);
    run_frame("t4_neg_lane0", 2, 1'b1, 1, -1, 0, 0);
    run_frame("t5_sat_pos", 64, 1'b1, 0, 127, 0, 0);
    run_frame("t5_wrap_pos", 64, 1'b0, 0, 127, 0, 0);
    run_frame("t5_sat_neg", 64, 1'b1, 0, -128, 0, 0);
    run_frame("t6_backpressure", 5, 1'b0, 2, 60, 1, 10);
    run_frame("cfg_zero", 0, 1'b1, 2, 100, 0, 2);
    run_frame("cfg_over_max", 300, 1'b0, 2, 127, 0, 0);

    // Reset in the middle of an accumulating frame
    cfg_beats = BW'(8); cfg_sat = 1'b1; in_vec = {LN{8'sd5}};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset.in_ready", longint'(in_ready), 1);
    chk("midreset.out_valid", longint'(out_valid), 0);
    chk("midreset.sum", longint'(out_sum), 0);
    chk("midreset.comp", longint'(out_comp), 0);
    chk("midreset.ovf", longint'(out_ovf), 0);
    repeat (4) @(negedge clk);
    chk("midreset.flushed_sum", longint'(out_sum), 0);
    chk("midreset.no_result", longint'(out_valid), 0);
    run_frame("after_reset", 3, 1'b1, 0, 7, 0, 0);

    for (int r = 0; r < 8; r++) begin
      run_frame($sformatf("rand%0d", r), int'($urandom_range(1, 24)), 1'($urandom),
                2, int'($urandom_range(1, 127)), 2, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
